// File: rtl/dmem_arb_pkg.sv
// Shared constants and address helpers for the data-memory bank arbiter.
package dmem_arb_pkg;

  localparam int NUM_CORES    = 4;
  localparam int NUM_BANKS    = 4;
  localparam int BANK_IDX_W   = 2;
  localparam int DEF_BANK_AW  = 8;
  localparam int DEF_BANK_LSB = 2;

  // Word-interleaved bank index taken from the byte address.
  function automatic logic [BANK_IDX_W-1:0] bank_of(input logic [31:0] addr, input int lsb);
    return addr[lsb +: BANK_IDX_W];
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: one-hot grant, 2-bit pointer that moves past the winner.
module rr_arbiter4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt,
  output logic [1:0] o_ptr
);

  logic [1:0] r_ptr;
  logic [1:0] w_idx;
  logic [1:0] w_win;

  // Scan from the farthest offset back to the pointer so the nearest requester wins last.
  always_comb begin
    o_gnt = '0;
    w_idx = '0;
    w_win = r_ptr;
    for (int off = 3; off >= 0; off--) begin
      w_idx = r_ptr + 2'(off);
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
        w_win        = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= 2'd0;
    end else if (|i_req) begin
      r_ptr <= w_win + 2'd1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/dmem_bank_arbiter.sv
// Routes four core data ports onto four word-interleaved single-port banks with
// per-bank round-robin arbitration and a one-cycle registered read response.
module dmem_bank_arbiter #(
  parameter int NUM_CORES = dmem_arb_pkg::NUM_CORES,
  parameter int NUM_BANKS = dmem_arb_pkg::NUM_BANKS,
  parameter int BANK_AW   = dmem_arb_pkg::DEF_BANK_AW,
  parameter int BANK_LSB  = dmem_arb_pkg::DEF_BANK_LSB
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CORES-1:0]           core_req,
  input  logic [NUM_CORES-1:0]           core_we,
  input  logic [NUM_CORES*32-1:0]        core_addr,
  input  logic [NUM_CORES*32-1:0]        core_wdata,
  output logic [NUM_CORES-1:0]           core_stall,
  output logic [NUM_CORES-1:0]           core_rvalid,
  output logic [NUM_CORES*32-1:0]        core_rdata,
  output logic [NUM_BANKS-1:0]           bank_en,
  output logic [NUM_BANKS-1:0]           bank_we,
  output logic [NUM_BANKS*BANK_AW-1:0]   bank_addr,
  output logic [NUM_BANKS*32-1:0]        bank_wdata,
  input  logic [NUM_BANKS*32-1:0]        bank_rdata
);

  import dmem_arb_pkg::*;

  // Handshake: a core presents core_req with we/addr/wdata and holds them while
  // core_stall is high; the access is accepted in any cycle where req=1 and stall=0.
  logic [NUM_CORES-1:0]  w_req;
  logic [NUM_CORES-1:0]  w_granted;
  logic [NUM_CORES-1:0]  w_rd_grant;
  logic [BANK_IDX_W-1:0] w_core_bank [NUM_CORES];
  logic [NUM_CORES-1:0]  w_bank_req  [NUM_BANKS];
  logic [NUM_CORES-1:0]  w_bank_gnt  [NUM_BANKS];
  logic [1:0]            w_rr_ptr    [NUM_BANKS];
  logic [NUM_CORES*32-1:0] w_live_rdata;
  logic                  w_unused_ptr;

  logic [NUM_CORES-1:0]    r_resp_pend;
  logic [BANK_IDX_W-1:0]   r_resp_bank [NUM_CORES];
  logic [NUM_CORES*32-1:0] r_rdata_hold;

  // Requests are masked during reset so no bank is touched and nobody stalls.
  always_comb begin
    w_req = core_req & {NUM_CORES{rst_n}};
    for (int c = 0; c < NUM_CORES; c++) begin
      w_core_bank[c] = bank_of(core_addr[32*c +: 32], BANK_LSB);
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_req[b] = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        w_bank_req[b][c] = w_req[c] && (w_core_bank[c] == BANK_IDX_W'(b));
      end
    end
  end

  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank_arb
    rr_arbiter4 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (w_bank_req[gb]),
      .o_gnt (w_bank_gnt[gb]),
      .o_ptr (w_rr_ptr[gb])
    );
  end

  always_comb begin
    bank_en    = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    w_granted  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_en[b] = |w_bank_gnt[b];
      for (int c = 0; c < NUM_CORES; c++) begin
        if (w_bank_gnt[b][c]) begin
          bank_we[b]                       = core_we[c];
          bank_addr[b*BANK_AW +: BANK_AW]  = core_addr[32*c + BANK_LSB + BANK_IDX_W +: BANK_AW];
          bank_wdata[32*b +: 32]           = core_wdata[32*c +: 32];
          w_granted[c]                     = 1'b1;
        end
      end
    end
    core_stall = w_req & ~w_granted;
    w_rd_grant = w_granted & ~core_we;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resp_pend  <= '0;
      r_rdata_hold <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        r_resp_bank[c] <= '0;
      end
    end else begin
      r_resp_pend <= w_rd_grant;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (w_rd_grant[c]) begin
          r_resp_bank[c] <= w_core_bank[c];
        end
        if (r_resp_pend[c]) begin
          r_rdata_hold[32*c +: 32] <= w_live_rdata[32*c +: 32];
        end
      end
    end
  end

  // Live bank data is shown during rvalid; afterwards the captured copy holds it.
  always_comb begin
    core_rvalid  = r_resp_pend & {NUM_CORES{rst_n}};
    w_live_rdata = '0;
    core_rdata   = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      w_live_rdata[32*c +: 32] = bank_rdata[32*r_resp_bank[c] +: 32];
      core_rdata[32*c +: 32]   = core_rvalid[c] ? w_live_rdata[32*c +: 32]
                                                : r_rdata_hold[32*c +: 32];
    end
  end

  // Pointer state is kept visible for checker binding; the datapath does not consume it.
  always_comb begin
    w_unused_ptr = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_unused_ptr = w_unused_ptr ^ (^w_rr_ptr[b]);
    end
  end

endmodule

// File: tb/tb_dmem_bank_arbiter.sv
// Directed bench for dmem_bank_arbiter with a behavioural 4-bank memory model.
module tb_dmem_bank_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    core_req, core_we;
  logic [127:0]  core_addr, core_wdata;
  logic [3:0]    core_stall, core_rvalid;
  logic [127:0]  core_rdata;
  logic [3:0]    bank_en, bank_we;
  logic [4*AW-1:0] bank_addr;
  logic [127:0]  bank_wdata;
  logic [127:0]  bank_rdata;

  logic [31:0]   m_mem [4][256];
  int            n_checks = 0;
  int            n_errors = 0;

  always #5 clk = ~clk;

  dmem_bank_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_stall  (core_stall),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .bank_en     (bank_en),
    .bank_we     (bank_we),
    .bank_addr   (bank_addr),
    .bank_wdata  (bank_wdata),
    .bank_rdata  (bank_rdata)
  );

  // Single-port synchronous banks: write on the access edge, read data one cycle later.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) m_mem[b][bank_addr[b*AW +: AW]] <= bank_wdata[32*b +: 32];
        else            bank_rdata[32*b +: 32] <= m_mem[b][bank_addr[b*AW +: AW]];
      end
    end
  end

  function automatic logic [31:0] pat(input int b, input int w);
    return 32'hA000_0000 | (32'(b) << 16) | 32'(w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req   = '0;
    core_we    = '0;
    core_addr  = '0;
    core_wdata = '0;
  endtask

  task automatic set_core(input int c, input logic we, input logic [31:0] a, input logic [31:0] d);
    core_req[c]            = 1'b1;
    core_we[c]             = we;
    core_addr[32*c +: 32]  = a;
    core_wdata[32*c +: 32] = d;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) set_core(c, 1'b0, 32'(4*c), 32'h0);
    @(negedge clk);
    n_checks++; if (core_stall !== 4'b0000) begin n_errors++; $display("FAIL reset_stall: got %b want 0000", core_stall); end
    n_checks++; if (bank_en !== 4'b0000) begin n_errors++; $display("FAIL reset_bank_en: got %b want 0000", bank_en); end
    n_checks++; if (bank_we !== 4'b0000) begin n_errors++; $display("FAIL reset_bank_we: got %b want 0000", bank_we); end
    n_checks++; if (core_rvalid !== 4'b0000) begin n_errors++; $display("FAIL reset_rvalid: got %b want 0000", core_rvalid); end
    tick();
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (core_rvalid !== 4'b0000) begin n_errors++; $display("FAIL post_reset_rvalid: got %b want 0000", core_rvalid); end
    n_checks++; if (core_rdata !== 128'h0) begin n_errors++; $display("FAIL post_reset_rdata: got %h want 0", core_rdata); end
    tick();
  endtask

  task automatic test_distinct_banks();
    for (int c = 0; c < 4; c++) set_core(c, 1'b0, 32'(4*c), 32'h0);
    @(negedge clk);
    n_checks++; if (core_stall !== 4'b0000) begin n_errors++; $display("FAIL distinct_stall: got %b want 0000", core_stall); end
    n_checks++; if (bank_en !== 4'b1111) begin n_errors++; $display("FAIL distinct_bank_en: got %b want 1111", bank_en); end
    n_checks++; if (bank_we !== 4'b0000) begin n_errors++; $display("FAIL distinct_bank_we: got %b want 0000", bank_we); end
    n_checks++; if (bank_addr !== 32'h0) begin n_errors++; $display("FAIL distinct_bank_addr: got %h want 0", bank_addr); end
    tick();
    idle();
    @(negedge clk);
    n_checks++; if (core_rvalid !== 4'b1111) begin n_errors++; $display("FAIL distinct_rvalid: got %b want 1111", core_rvalid); end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (core_rdata[32*c +: 32] !== pat(c, 0)) begin
        n_errors++; $display("FAIL distinct_rdata core%0d: got %h want %h", c, core_rdata[32*c +: 32], pat(c, 0));
      end
    end
    tick();
    @(negedge clk);
    n_checks++; if (core_rvalid !== 4'b0000) begin n_errors++; $display("FAIL distinct_rvalid_drop: got %b want 0000", core_rvalid); end
    n_checks++; if (core_rdata[32*2 +: 32] !== pat(2, 0)) begin n_errors++; $display("FAIL distinct_rdata_hold: got %h want %h", core_rdata[32*2 +: 32], pat(2, 0)); end
    tick();
  endtask

  // Four reads to bank 0 words 0..3; core k wins at cycle k and drops its request.
  task automatic test_full_conflict();
    logic [3:0] exp_stall [4];
    exp_stall[0] = 4'b1110; exp_stall[1] = 4'b1100; exp_stall[2] = 4'b1000; exp_stall[3] = 4'b0000;
    do_reset();
    for (int c = 0; c < 4; c++) set_core(c, 1'b0, 32'(16*c), 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        n_checks++; if (core_stall !== exp_stall[k]) begin n_errors++; $display("FAIL conflict_stall k=%0d: got %b want %b", k, core_stall, exp_stall[k]); end
        n_checks++; if (bank_en !== 4'b0001) begin n_errors++; $display("FAIL conflict_bank_en k=%0d: got %b want 0001", k, bank_en); end
        n_checks++; if (bank_addr[7:0] !== 8'(k)) begin n_errors++; $display("FAIL conflict_bank_addr k=%0d: got %0d want %0d", k, bank_addr[7:0], k); end
      end else begin
        n_checks++; if (bank_en !== 4'b0000) begin n_errors++; $display("FAIL conflict_idle_bank_en: got %b want 0000", bank_en); end
      end
      if (k == 0) begin
        n_checks++; if (core_rvalid !== 4'b0000) begin n_errors++; $display("FAIL conflict_rvalid k=0: got %b want 0000", core_rvalid); end
      end else begin
        n_checks++; if (core_rvalid !== 4'(1 << (k-1))) begin n_errors++; $display("FAIL conflict_rvalid k=%0d: got %b want %b", k, core_rvalid, 4'(1 << (k-1))); end
        n_checks++; if (core_rdata[32*(k-1) +: 32] !== pat(0, k-1)) begin n_errors++; $display("FAIL conflict_rdata k=%0d: got %h want %h", k, core_rdata[32*(k-1) +: 32], pat(0, k-1)); end
      end
      tick();
      if (k < 4) core_req[k] = 1'b0;
    end
  endtask

  task automatic test_write_read_order();
    do_reset();
    set_core(1, 1'b1, 32'h14, 32'hDEADBEEF);
    set_core(2, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    n_checks++; if (core_stall !== 4'b0100) begin n_errors++; $display("FAIL wr_stall: got %b want 0100", core_stall); end
    n_checks++; if (bank_we !== 4'b0010) begin n_errors++; $display("FAIL wr_bank_we: got %b want 0010", bank_we); end
    n_checks++; if (bank_addr[15:8] !== 8'd1) begin n_errors++; $display("FAIL wr_bank_addr: got %0d want 1", bank_addr[15:8]); end
    n_checks++; if (bank_wdata[63:32] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_bank_wdata: got %h want deadbeef", bank_wdata[63:32]); end
    tick();
    core_req[1] = 1'b0;
    @(negedge clk);
    n_checks++; if (core_stall !== 4'b0000) begin n_errors++; $display("FAIL rd_after_wr_stall: got %b want 0000", core_stall); end
    n_checks++; if (bank_en !== 4'b0010 || bank_we !== 4'b0000) begin n_errors++; $display("FAIL rd_after_wr_bank: got en=%b we=%b want en=0010 we=0000", bank_en, bank_we); end
    n_checks++; if (core_rvalid !== 4'b0000) begin n_errors++; $display("FAIL wr_no_response: got %b want 0000", core_rvalid); end
    tick();
    idle();
    @(negedge clk);
    n_checks++; if (core_rvalid !== 4'b0100) begin n_errors++; $display("FAIL rd_after_wr_rvalid: got %b want 0100", core_rvalid); end
    n_checks++; if (core_rdata[95:64] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_after_wr_rdata: got %h want deadbeef", core_rdata[95:64]); end
    tick();
  endtask

  // Cores 0 and 2 both hammer bank 3; grants must alternate 0,2,0,2...
  task automatic test_round_robin();
    logic [3:0] exp_stall;
    logic [3:0] exp_rv;
    int         prev_c;
    do_reset();
    set_core(0, 1'b0, 32'h0C, 32'h0);
    set_core(2, 1'b0, 32'h1C, 32'h0);
    for (int k = 0; k < 9; k++) begin
      if (k == 8) idle();
      @(negedge clk);
      if (k < 8) begin
        exp_stall = (k % 2 == 0) ? 4'b0100 : 4'b0001;
        n_checks++; if (core_stall !== exp_stall) begin n_errors++; $display("FAIL rr_stall k=%0d: got %b want %b", k, core_stall, exp_stall); end
        n_checks++; if (bank_addr[31:24] !== 8'(k % 2)) begin n_errors++; $display("FAIL rr_bank_addr k=%0d: got %0d want %0d", k, bank_addr[31:24], k % 2); end
      end
      if (k > 0) begin
        prev_c = ((k - 1) % 2 == 0) ? 0 : 2;
        exp_rv = 4'(1 << prev_c);
        n_checks++; if (core_rvalid !== exp_rv) begin n_errors++; $display("FAIL rr_rvalid k=%0d: got %b want %b", k, core_rvalid, exp_rv); end
        n_checks++; if (core_rdata[32*prev_c +: 32] !== pat(3, (k-1) % 2)) begin n_errors++; $display("FAIL rr_rdata k=%0d: got %h want %h", k, core_rdata[32*prev_c +: 32], pat(3, (k-1) % 2)); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 4; c++) set_core(c, 1'b0, 32'(16*c), 32'h0);
    @(negedge clk);
    n_checks++; if (core_stall !== 4'b1110) begin n_errors++; $display("FAIL mid_pre_stall: got %b want 1110", core_stall); end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (core_rvalid !== 4'b0000) begin n_errors++; $display("FAIL mid_rst_rvalid: got %b want 0000", core_rvalid); end
    n_checks++; if (core_stall !== 4'b0000) begin n_errors++; $display("FAIL mid_rst_stall: got %b want 0000", core_stall); end
    n_checks++; if (bank_en !== 4'b0000 || bank_we !== 4'b0000) begin n_errors++; $display("FAIL mid_rst_bank: got en=%b we=%b want 0000", bank_en, bank_we); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (core_rvalid !== 4'b0000) begin n_errors++; $display("FAIL mid_rel_rvalid: got %b want 0000", core_rvalid); end
    n_checks++; if (core_rdata !== 128'h0) begin n_errors++; $display("FAIL mid_rel_rdata: got %h want 0", core_rdata); end
    n_checks++; if (core_stall !== 4'b1110) begin n_errors++; $display("FAIL mid_rel_stall: got %b want 1110", core_stall); end
    n_checks++; if (bank_en !== 4'b0001 || bank_addr[7:0] !== 8'd0) begin n_errors++; $display("FAIL mid_rel_winner: got en=%b addr=%0d want 0001/0", bank_en, bank_addr[7:0]); end
    tick();
    idle();
    @(negedge clk);
    n_checks++; if (core_rvalid !== 4'b0001) begin n_errors++; $display("FAIL mid_rel_rvalid2: got %b want 0001", core_rvalid); end
    n_checks++; if (core_rdata[31:0] !== pat(0, 0)) begin n_errors++; $display("FAIL mid_rel_rdata2: got %h want %h", core_rdata[31:0], pat(0, 0)); end
    tick();
  endtask

  // 0x17 and 0xFFFFF014 both land on bank 1 word 1, which holds DEADBEEF by now.
  task automatic test_alias();
    set_core(3, 1'b0, 32'h17, 32'h0);
    @(negedge clk);
    n_checks++; if (bank_en !== 4'b0010 || bank_we !== 4'b0000) begin n_errors++; $display("FAIL alias_bank: got en=%b we=%b want 0010/0000", bank_en, bank_we); end
    n_checks++; if (bank_addr[15:8] !== 8'd1) begin n_errors++; $display("FAIL alias_bank_addr: got %0d want 1", bank_addr[15:8]); end
    n_checks++; if (core_stall !== 4'b0000) begin n_errors++; $display("FAIL alias_stall: got %b want 0000", core_stall); end
    tick();
    idle();
    set_core(0, 1'b0, 32'hFFFF_F014, 32'h0);
    @(negedge clk);
    n_checks++; if (core_rvalid !== 4'b1000) begin n_errors++; $display("FAIL alias_rvalid: got %b want 1000", core_rvalid); end
    n_checks++; if (core_rdata[127:96] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL alias_rdata: got %h want deadbeef", core_rdata[127:96]); end
    n_checks++; if (bank_en !== 4'b0010 || bank_addr[15:8] !== 8'd1) begin n_errors++; $display("FAIL alias_high_bank: got en=%b addr=%0d want 0010/1", bank_en, bank_addr[15:8]); end
    tick();
    idle();
    @(negedge clk);
    n_checks++; if (core_rvalid !== 4'b0001) begin n_errors++; $display("FAIL alias_high_rvalid: got %b want 0001", core_rvalid); end
    n_checks++; if (core_rdata[31:0] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL alias_high_rdata: got %h want deadbeef", core_rdata[31:0]); end
    n_checks++; if (core_rdata[127:96] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL alias_rdata_hold: got %h want deadbeef", core_rdata[127:96]); end
    tick();
  endtask

  initial begin
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 256; w++)
        m_mem[b][w] = pat(b, w);
    bank_rdata = '0;
    idle();
    rst_n = 1'b0;
    test_reset();
    test_distinct_banks();
    test_full_conflict();
    test_write_read_order();
    test_round_robin();
    test_reset_mid();
    test_alias();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
